// File: rtl/flag_writer.sv
// +--------------------------------------------------------------------------+
// | flag_writer : two-stage NZCV flag commit with a 4-deep shadow stack      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module flag_writer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [1:0] upd_flagw,
  input  logic [3:0] upd_aluflags,
  input  logic       upd_condex,
  input  logic       save_req,
  input  logic       restore_req,
  output logic [3:0] Flags,
  output logic       flags_valid,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] pend_mask;
  logic [3:0] pend_flags;
  logic [2:0] ptr;
  logic [3:0] stack [4];
  logic [1:0] pop_idx;

  // ptr is 1..4 whenever a pop happens, so the low bits minus one wrap 4 -> 3.
  assign pop_idx     = ptr[1:0] - 2'd1;

  assign upd_ready   = (state == IDLE);
  assign flags_valid = (state == IDLE);
  assign stk_empty   = (ptr == 3'd0);
  assign stk_full    = (ptr == 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      Flags      <= 4'b0000;
      pend_mask  <= 2'b00;
      pend_flags <= 4'b0000;
      ptr        <= 3'd0;
      stk_err    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stack[i] <= 4'b0000;
      end
    end else begin
      case (state)
        IDLE: begin
          // An accepted update (even a squashed one) blocks stack activity.
          if (upd_valid) begin
            if (upd_condex && (upd_flagw != 2'b00)) begin
              pend_mask  <= upd_flagw;
              pend_flags <= upd_aluflags;
              state      <= PEND;
            end
          end else if (restore_req) begin
            if (ptr != 3'd0) begin
              ptr   <= ptr - 3'd1;
              Flags <= stack[pop_idx];
            end else begin
              stk_err <= 1'b1;
            end
          end else if (save_req) begin
            if (ptr != 3'd4) begin
              stack[ptr[1:0]] <= Flags;
              ptr             <= ptr + 3'd1;
            end else begin
              stk_err <= 1'b1;
            end
          end
        end
        PEND: begin
          if (pend_mask[1]) Flags[3:2] <= pend_flags[3:2];
          if (pend_mask[0]) Flags[1:0] <= pend_flags[1:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flag_writer.sv
// +--------------------------------------------------------------------------+
// | tb_flag_writer : directed and random checks of flag_writer               |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_flag_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [1:0] upd_flagw = 2'b00;
  logic [3:0] upd_aluflags = 4'b0000;
  logic       upd_condex = 1'b0;
  logic       save_req = 1'b0;
  logic       restore_req = 1'b0;
  logic [3:0] Flags;
  logic       flags_valid;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending update plus a LIFO queue of saved flags
  bit       m_pend;
  bit [1:0] m_pmask;
  bit [3:0] m_pflags;
  bit [3:0] m_flags;
  bit [3:0] m_stk[$];
  bit       m_err;

  flag_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_flagw    (upd_flagw),
    .upd_aluflags (upd_aluflags),
    .upd_condex   (upd_condex),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .Flags        (Flags),
    .flags_valid  (flags_valid),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .stk_err      (stk_err)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {Flags, upd_ready, flags_valid, stk_full, stk_empty, stk_err};

  function automatic logic [8:0] model_out();
    return {m_flags, !m_pend, !m_pend, m_stk.size() == 4, m_stk.size() == 0, m_err};
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_pmask = 0; m_pflags = 0; m_flags = 0; m_err = 0;
    m_stk.delete();
  endfunction

  function automatic void model_step();
    if (m_pend) begin
      for (int b = 0; b < 4; b++)
        if (m_pmask[b/2]) m_flags[b] = m_pflags[b];
      m_pend = 0;
    end else if (upd_valid) begin
      if (upd_condex && upd_flagw != 0) begin
        m_pend = 1; m_pmask = upd_flagw; m_pflags = upd_aluflags;
      end
    end else if (restore_req) begin
      if (m_stk.size() > 0) m_flags = m_stk.pop_back();
      else m_err = 1;
    end else if (save_req) begin
      if (m_stk.size() < 4) m_stk.push_back(m_flags);
      else m_err = 1;
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] fw, input logic [3:0] af,
                       input logic cx, input logic sv, input logic rs);
    upd_valid = v; upd_flagw = fw; upd_aluflags = af; upd_condex = cx;
    save_req = sv; restore_req = rs;
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    upd_valid = 0; upd_flagw = 0; upd_aluflags = 0; upd_condex = 0;
    save_req = 0; restore_req = 0;
    @(negedge clk); reset_n = 0;
    @(negedge clk); @(negedge clk); reset_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 0;
    #2;
    vectors++;
    if (obs !== 9'b0000_1_1_0_1_0) begin
      $display("FAIL reset_state: got %b expected %b", obs, 9'b0000_1_1_0_1_0);
      miscompares++;
    end
    @(negedge clk); reset_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_update();
    apply_reset();
    drive(1, 2'b11, 4'b1010, 1, 0, 0);
    vectors++;
    if ({upd_ready, flags_valid, Flags} !== 6'b00_0000) begin
      $display("FAIL update_pend: got %b expected %b", {upd_ready, flags_valid, Flags}, 6'b00_0000);
      miscompares++;
    end
    idle();
    vectors++;
    if ({upd_ready, flags_valid, Flags} !== 6'b11_1010) begin
      $display("FAIL update_commit: got %b expected %b", {upd_ready, flags_valid, Flags}, 6'b11_1010);
      miscompares++;
    end
    drive(1, 2'b11, 4'b1111, 1, 0, 0); idle();
    drive(1, 2'b10, 4'b0000, 1, 0, 0); idle();
    vectors++;
    if (Flags !== 4'b0011) begin
      $display("FAIL mask_nz: got %b expected %b", Flags, 4'b0011);
      miscompares++;
    end
    drive(1, 2'b01, 4'b0000, 1, 0, 0); idle();
    vectors++;
    if (Flags !== 4'b0000) begin
      $display("FAIL mask_cv: got %b expected %b", Flags, 4'b0000);
      miscompares++;
    end
  endtask

  task automatic test_squash();
    drive(1, 2'b11, 4'b0110, 1, 0, 0); idle();
    drive(1, 2'b11, 4'b1001, 0, 0, 0);
    vectors++;
    if ({upd_ready, flags_valid, Flags} !== 6'b11_0110) begin
      $display("FAIL squash_condex: got %b expected %b", {upd_ready, flags_valid, Flags}, 6'b11_0110);
      miscompares++;
    end
    drive(1, 2'b00, 4'b1001, 1, 0, 0);
    vectors++;
    if ({upd_ready, flags_valid, Flags} !== 6'b11_0110) begin
      $display("FAIL squash_nomask: got %b expected %b", {upd_ready, flags_valid, Flags}, 6'b11_0110);
      miscompares++;
    end
    idle();
    vectors++;
    if (Flags !== 4'b0110) begin
      $display("FAIL squash_hold: got %b expected %b", Flags, 4'b0110);
      miscompares++;
    end
  endtask

  task automatic test_stack();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 2'b11, 4'(i), 1, 0, 0); idle();
      drive(0, 2'b00, 4'b0000, 0, 1, 0);
    end
    vectors++;
    if ({stk_full, stk_empty, stk_err} !== 3'b100) begin
      $display("FAIL stack_full: got %b expected %b", {stk_full, stk_empty, stk_err}, 3'b100);
      miscompares++;
    end
    drive(0, 2'b00, 4'b0000, 0, 1, 0);
    vectors++;
    if ({stk_full, stk_err} !== 2'b11) begin
      $display("FAIL push_on_full: got %b expected %b", {stk_full, stk_err}, 2'b11);
      miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 2'b00, 4'b0000, 0, 0, 1);
      vectors++;
      if (Flags !== 4'(4 - k)) begin
        $display("FAIL restore_%0d: got %b expected %b", k, Flags, 4'(4 - k));
        miscompares++;
      end
    end
    vectors++;
    if ({stk_full, stk_empty} !== 2'b01) begin
      $display("FAIL stack_empty: got %b expected %b", {stk_full, stk_empty}, 2'b01);
      miscompares++;
    end
    drive(0, 2'b00, 4'b0000, 0, 0, 1);
    vectors++;
    if ({Flags, stk_empty, stk_err} !== 6'b0001_1_1) begin
      $display("FAIL pop_on_empty: got %b expected %b", {Flags, stk_empty, stk_err}, 6'b0001_1_1);
      miscompares++;
    end
  endtask

  task automatic test_priority();
    apply_reset();
    drive(1, 2'b11, 4'b0101, 1, 0, 0); idle();
    drive(0, 2'b00, 4'b0000, 0, 1, 0);
    drive(1, 2'b11, 4'b1100, 1, 1, 1);
    vectors++;
    if ({upd_ready, stk_empty, stk_full, stk_err} !== 4'b0000) begin
      $display("FAIL upd_over_stack: got %b expected %b", {upd_ready, stk_empty, stk_full, stk_err}, 4'b0000);
      miscompares++;
    end
    // stack requests during the pending cycle must be ignored
    drive(0, 2'b00, 4'b0000, 0, 1, 1);
    vectors++;
    if ({Flags, stk_empty, stk_err} !== 6'b1100_0_0) begin
      $display("FAIL pend_ignore: got %b expected %b", {Flags, stk_empty, stk_err}, 6'b1100_0_0);
      miscompares++;
    end
    drive(0, 2'b00, 4'b0000, 0, 1, 1);
    vectors++;
    if ({Flags, stk_empty, stk_err} !== 6'b0101_1_0) begin
      $display("FAIL restore_over_save: got %b expected %b", {Flags, stk_empty, stk_err}, 6'b0101_1_0);
      miscompares++;
    end
    vectors++;
    if (obs !== model_out()) begin
      $display("FAIL priority_model: got %b expected %b", obs, model_out());
      miscompares++;
    end
  endtask

  task automatic test_reset_in_pend();
    drive(0, 2'b00, 4'b0000, 0, 0, 1);
    drive(0, 2'b00, 4'b0000, 0, 0, 1);
    drive(1, 2'b11, 4'b1111, 1, 0, 0);
    upd_valid = 0;
    reset_n = 0;
    #2;
    vectors++;
    if ({Flags, upd_ready, stk_err} !== 6'b0000_1_0) begin
      $display("FAIL reset_in_pend: got %b expected %b", {Flags, upd_ready, stk_err}, 6'b0000_1_0);
      miscompares++;
    end
    @(negedge clk); reset_n = 1;
    model_reset();
    idle();
    vectors++;
    if ({Flags, upd_ready, flags_valid, stk_err} !== 7'b0000_1_1_0) begin
      $display("FAIL after_reset_pend: got %b expected %b", {Flags, upd_ready, flags_valid, stk_err}, 7'b0000_1_1_0);
      miscompares++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 500; n++) begin
      drive(logic'($urandom_range(0, 2) == 0), 2'($urandom), 4'($urandom),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 3) == 0));
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL random_%0d: got %b expected %b", n, obs, model_out());
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_squash();
    test_stack();
    test_priority();
    test_reset_in_pend();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
